// File: rtl/conv_acc_pkg.sv
// conv_acc_pkg: shared types and constants for the convolution accelerator result path
package conv_acc_pkg;
  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;
  localparam int LANES = 4;
  function automatic int lane_lsb(input int k, input int w);
    return k * w;
  endfunction
endpackage

// File: rtl/result_ram.sv
// result_ram: word buffer with one synchronous write port and LANES asynchronous read ports at raddr+0..LANES-1
module result_ram
  import conv_acc_pkg::*;
#(
  parameter int DATA_WIDTH2   = 32,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                                clk,
  input  logic                                we,
  input  logic [ADDRESS_WIDTH-1:0]            waddr,
  input  logic [DATA_WIDTH2-1:0]              wdata,
  input  logic [ADDRESS_WIDTH-1:0]            raddr,
  output logic [LANES-1:0][DATA_WIDTH2-1:0]   rdata
);
  logic [DATA_WIDTH2-1:0] mem [2**ADDRESS_WIDTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_comb
    for (int k = 0; k < LANES; k++) rdata[k] = mem[raddr + ADDRESS_WIDTH'(k)];
endmodule

// File: rtl/output_result_packer.sv
// output_result_packer: buffers a frame of result words, then drains them as packed LANES-word beats.
// Define OUT_MEM_RELU_EN to store negative words as zero.
module output_result_packer
  import conv_acc_pkg::*;
#(
  parameter int DATA_WIDTH    = 128,
  parameter int DATA_WIDTH2   = 32,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     En,
  input  logic                     Res_Valid,
  input  logic [DATA_WIDTH2-1:0]   Res_Data,
  input  logic                     Res_Last,
  output logic                     Res_Ready,
  output logic [DATA_WIDTH-1:0]    Data_Out,
  output logic                     Out_Valid,
  output logic                     Out_Last,
  input  logic                     Out_Ready,
  output logic [ADDRESS_WIDTH:0]   Word_Count,
  output logic                     Overflow
);
  localparam int DEPTH = 2**ADDRESS_WIDTH;
  localparam int PW    = ADDRESS_WIDTH + 2;
  state_t state, state_nx;
  logic [ADDRESS_WIDTH-1:0] wr_ptr;
  logic [ADDRESS_WIDTH:0] rd_ptr, load_cnt;
  logic [LANES-1:0][DATA_WIDTH2-1:0] rd_data, beat;
  logic [DATA_WIDTH2-1:0] wdata;
  logic wr_hs, out_hs, full_wr, fill_done, load, beat_last;
`ifdef OUT_MEM_RELU_EN
  assign wdata = Res_Data[DATA_WIDTH2-1] ? '0 : Res_Data;
`else
  assign wdata = Res_Data;
`endif
  assign Res_Ready = state == FILL;
  assign wr_hs     = Res_Valid && Res_Ready;
  assign out_hs    = Out_Valid && Out_Ready;
  assign full_wr   = wr_hs && Word_Count == (ADDRESS_WIDTH+1)'(DEPTH - 1);
  assign fill_done = wr_hs && (Res_Last || full_wr);
  assign load_cnt  = Word_Count + (ADDRESS_WIDTH+1)'(wr_hs);
  assign load      = fill_done || (state == DRAIN && out_hs && !Out_Last);
  assign beat_last = PW'(rd_ptr) + PW'(LANES) >= PW'(load_cnt);
  result_ram #(.DATA_WIDTH2(DATA_WIDTH2), .ADDRESS_WIDTH(ADDRESS_WIDTH)) u_ram (
    .clk   (clk),
    .we    (wr_hs),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr[ADDRESS_WIDTH-1:0]),
    .rdata (rd_data)
  );
  // the word written on the closing edge is not in the RAM yet, so it is forwarded into the first beat
  always_comb
    for (int k = 0; k < LANES; k++)
      beat[k] = PW'(rd_ptr) + PW'(k) >= PW'(load_cnt) ? '0 :
                (wr_hs && rd_ptr[ADDRESS_WIDTH-1:0] + ADDRESS_WIDTH'(k) == wr_ptr) ? wdata : rd_data[k];
  always_comb
    state_nx = !En ? IDLE :
               state == IDLE ? FILL :
               (state == FILL && fill_done) ? DRAIN :
               (state == DRAIN && out_hs && Out_Last) ? IDLE : state;
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : state_nx;
  always_ff @(posedge clk)
    if (!rst_n || !En) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      Word_Count <= '0;
      Overflow   <= 1'b0;
      Out_Valid  <= 1'b0;
      Out_Last   <= 1'b0;
      Data_Out   <= '0;
    end else begin
      if (wr_hs) begin
        wr_ptr     <= wr_ptr + 1'b1;
        Word_Count <= load_cnt;
      end
      if (full_wr && !Res_Last) Overflow <= 1'b1;
      if (load) begin
        Data_Out  <= DATA_WIDTH'(beat);
        Out_Valid <= 1'b1;
        Out_Last  <= beat_last;
        rd_ptr    <= rd_ptr + (ADDRESS_WIDTH+1)'(LANES);
      end else if (out_hs && Out_Last) begin
        Out_Valid  <= 1'b0;
        Out_Last   <= 1'b0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        Word_Count <= '0;
      end
    end
endmodule

// File: tb/tb_output_result_packer.sv
// tb_output_result_packer: table, directed and randomized frames checked against a queue-based model
module tb_output_result_packer;
  import conv_acc_pkg::*;
  logic clk = 0, rst_n, En, Res_Valid, Res_Last, Res_Ready, Out_Valid, Out_Last, Out_Ready, Overflow;
  logic [31:0] Res_Data;
  logic [127:0] Data_Out;
  logic [8:0] Word_Count;
  int vec = 0, errs = 0;
  typedef struct {int n; logic [31:0] first; int nb; logic [127:0] b0; logic [127:0] bl;} vec_t;
  vec_t tbl[5];
  always #5 clk = ~clk;
  output_result_packer dut (
    .clk(clk), .rst_n(rst_n), .En(En), .Res_Valid(Res_Valid), .Res_Data(Res_Data),
    .Res_Last(Res_Last), .Res_Ready(Res_Ready), .Data_Out(Data_Out), .Out_Valid(Out_Valid),
    .Out_Last(Out_Last), .Out_Ready(Out_Ready), .Word_Count(Word_Count), .Overflow(Overflow)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    vec++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask
  function automatic logic [31:0] relu(input logic [31:0] w);
`ifdef OUT_MEM_RELU_EN
    return w[31] ? 32'h0 : w;
`else
    return w;
`endif
  endfunction
  function automatic logic [127:0] mbeat(input logic [31:0] w[$], input int b);
    logic [127:0] r = '0;
    for (int k = 0; k < LANES; k++)
      if (b * LANES + k < w.size()) r[lane_lsb(k, 32) +: 32] = relu(w[b * LANES + k]);
    return r;
  endfunction
  task automatic send(input logic [31:0] w[$], input bit last);
    for (int i = 0; i < w.size(); i++) begin
      int t = 0;
      Res_Valid = 1;
      Res_Data  = w[i];
      Res_Last  = last && i == w.size() - 1;
      while (!Res_Ready && t < 50) begin tick; t++; end
      chk("send_ready", Res_Ready, 1);
      tick;
    end
    Res_Valid = 0;
    Res_Last  = 0;
  endtask
  task automatic drain(input bit rnd, output logic [127:0] q[$]);
    logic [127:0] pd = '0;
    logic pl = 0;
    bit stall = 0, done = 0;
    int t = 0;
    q = {};
    while (!done && t < 3000) begin
      Out_Ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (Out_Valid) begin
        chk("res_ready_drain", Res_Ready, 0);
        if (stall) begin
          chk("hold_data", Data_Out, pd);
          chk("hold_last", Out_Last, pl);
        end
        stall = !Out_Ready;
        pd = Data_Out;
        pl = Out_Last;
        if (Out_Ready) begin
          q.push_back(Data_Out);
          done = Out_Last;
        end
      end
      tick;
      t++;
    end
    chk("drain_done", done, 1);
    Out_Ready = 0;
  endtask
  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  initial begin
    logic [31:0] w[$];
    logic [127:0] q[$], lb, exp_relu;
    rst_n = 0; En = 1; Res_Valid = 1; Res_Data = 32'h123; Res_Last = 0; Out_Ready = 0;
    tick; tick;
    chk("rst_res_ready", Res_Ready, 0);
    chk("rst_out_valid", Out_Valid, 0);
    chk("rst_out_last", Out_Last, 0);
    chk("rst_data", Data_Out, 0);
    chk("rst_count", Word_Count, 0);
    chk("rst_overflow", Overflow, 0);
    rst_n = 1; Res_Valid = 0;
    chk("rel_res_ready0", Res_Ready, 0);
    tick;
    chk("rel_res_ready1", Res_Ready, 1);
    tbl[0] = '{8, 32'h1, 2, 128'h00000004_00000003_00000002_00000001, 128'h00000008_00000007_00000006_00000005};
    tbl[1] = '{5, 32'hA, 2, 128'h0000000D_0000000C_0000000B_0000000A, 128'h00000000_00000000_00000000_0000000E};
    tbl[2] = '{4, 32'h100, 1, 128'h00000103_00000102_00000101_00000100, 128'h00000103_00000102_00000101_00000100};
    tbl[3] = '{1, 32'h55, 1, 128'h00000000_00000000_00000000_00000055, 128'h00000000_00000000_00000000_00000055};
    tbl[4] = '{3, 32'h7, 1, 128'h00000000_00000009_00000008_00000007, 128'h00000000_00000009_00000008_00000007};
    for (int v = 0; v < 5; v++) begin
      w = {};
      for (int i = 0; i < tbl[v].n; i++) w.push_back(tbl[v].first + 32'(i));
      send(w, 1);
      chk("tbl_count", Word_Count, 128'(tbl[v].n));
      chk("tbl_first_valid", Out_Valid, 1);
      drain(0, q);
      lb = q.size() > 0 ? q[q.size() - 1] : '0;
      chk("tbl_beats", 128'(q.size()), 128'(tbl[v].nb));
      chk("tbl_beat0", q.size() > 0 ? q[0] : '0, tbl[v].b0);
      chk("tbl_beat_last", lb, tbl[v].bl);
      chk("tbl_idle_valid", Out_Valid, 0);
      chk("tbl_idle_count", Word_Count, 0);
    end
    w = {};
    for (int i = 0; i < 12; i++) w.push_back(32'h20 + 32'(i));
    send(w, 1);
    Out_Ready = 1;
    chk("bp_beat0", Data_Out, mbeat(w, 0));
    tick;
    Out_Ready = 0;
    repeat (3) begin
      chk("bp_valid", Out_Valid, 1);
      chk("bp_hold", Data_Out, mbeat(w, 1));
      tick;
    end
    Out_Ready = 1;
    chk("bp_beat1", Data_Out, mbeat(w, 1));
    tick;
    chk("bp_beat2", Data_Out, mbeat(w, 2));
    chk("bp_last", Out_Last, 1);
    tick;
    chk("bp_done", Out_Valid, 0);
    Out_Ready = 0;
    w = {};
    for (int i = 0; i < 256; i++) w.push_back($urandom);
    send(w, 0);
    chk("full_overflow", Overflow, 1);
    chk("full_count", Word_Count, 256);
    Res_Valid = 1;
    drain(0, q);
    Res_Valid = 0;
    chk("full_beats", 128'(q.size()), 64);
    for (int b = 0; b < q.size(); b++) chk("full_beat", q[b], mbeat(w, b));
    chk("full_ovf_hold", Overflow, 1);
    tick;
    chk("full_no_257th", Word_Count, 0);
    w = {};
    for (int i = 0; i < 8; i++) w.push_back(32'h40 + 32'(i));
    send(w, 1);
    Out_Ready = 1;
    tick;
    En = 0; Out_Ready = 0;
    tick;
    chk("abort_valid", Out_Valid, 0);
    chk("abort_count", Word_Count, 0);
    chk("abort_overflow", Overflow, 0);
    chk("abort_ready", Res_Ready, 0);
    En = 1;
    w = {32'h50, 32'h51, 32'h52, 32'h53};
    send(w, 1);
    drain(0, q);
    chk("abort_new_beats", 128'(q.size()), 1);
    chk("abort_new_beat", q.size() > 0 ? q[0] : '0, 128'h00000053_00000052_00000051_00000050);
    w = {32'hFFFFFFFF, 32'h7};
`ifdef OUT_MEM_RELU_EN
    exp_relu = 128'h00000000_00000000_00000007_00000000;
`else
    exp_relu = 128'h00000000_00000000_00000007_FFFFFFFF;
`endif
    send(w, 1);
    drain(0, q);
    chk("relu_beat", q.size() > 0 ? q[0] : '0, exp_relu);
    for (int f = 0; f < 20; f++) begin
      int n = $urandom_range(1, 40);
      w = {};
      for (int i = 0; i < n; i++) w.push_back($urandom);
      send(w, 1);
      chk("rnd_count", Word_Count, 128'(n));
      drain(1, q);
      chk("rnd_beats", 128'(q.size()), 128'((n + 3) / 4));
      for (int b = 0; b < q.size(); b++) chk("rnd_beat", q[b], mbeat(w, b));
      chk("rnd_idle", Out_Valid, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
